// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt request-capture stage.
//   N_IRQ     : number of request lines (matches the 8-to-3 encoder input width)
//   IDX_W     : width of a line index, clog2(N_IRQ)
//   irq_vec_t : one bit per request line
//   irq_idx_t : index of one request line
package irq_pkg;

  localparam int N_IRQ = 8;
  localparam int IDX_W = 3;

  typedef logic [N_IRQ-1:0] irq_vec_t;
  typedef logic [IDX_W-1:0] irq_idx_t;

endpackage

// File: rtl/sync_ff_chain.sv
// Multi-bit flip-flop synchroniser. Each bit is an independent
// chain of STAGES flops, and the bits are not treated as a coherent bus.
// Ports:
//   clk   : destination clock
//   rst   : synchronous active-high reset, clears every stage
//   d     : asynchronous input bits
//   q     : synchronised bits (last stage of each chain)
module sync_ff_chain #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/irq_request_latch.sv
// Request-capture stage in front of the 8-to-3 priority encoder.
// Synchronises the raw interrupt lines, latches edge- or level-type
// requests into a pending register, and presents the masked pending
// vector to the encoder. The encoder's winning index comes back with an
// acknowledge that clears the corresponding pending bit.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   irq_in     : asynchronous request lines, active high
//   edge_mode  : per line, 1 = rising-edge triggered, 0 = level triggered
//   mask       : per line, 1 = hidden from pend_out (still pending)
//   pend_out   : registered pending & ~mask, feeds the encoder
//   irq_valid  : registered OR of pend_out
//   ack        : one-cycle service pulse for line ack_code
//   ack_code   : index being acknowledged, meaningful only with ack=1
//   ack_err    : one-cycle pulse, ack named a line not visible in pend_out
//   ovf        : sticky per line, a new edge arrived while already pending
//   clr_ovf    : clears all ovf bits
//
// Handshake: there is no ready/back-pressure. irq_valid=1 advertises that
// pend_out holds at least one request. The consumer answers with a single
// ack cycle naming the line it serviced. An ack is accepted only if that
// line is set in the currently registered pend_out. Otherwise it is
// flagged on ack_err and has no effect on state.
module irq_request_latch
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] irq_in,
  input  logic [7:0] edge_mode,
  input  logic [7:0] mask,
  output logic [7:0] pend_out,
  output logic       irq_valid,
  input  logic       ack,
  input  logic [2:0] ack_code,
  output logic       ack_err,
  output logic [7:0] ovf,
  input  logic       clr_ovf
);

  irq_vec_t s;
  irq_vec_t s_d;
  irq_vec_t pending;
  irq_vec_t rise;
  irq_vec_t set_vec;
  irq_vec_t clr_vec;
  irq_vec_t pending_next;
  irq_vec_t ovf_next;
  irq_vec_t visible_next;

  sync_ff_chain #(
    .WIDTH  (N_IRQ),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (irq_in),
    .q   (s)
  );

  always_comb begin
    rise    = s & ~s_d;
    set_vec = (edge_mode & rise) | (~edge_mode & s);

    clr_vec = '0;
    if (ack && pend_out[ack_code]) begin
      clr_vec[ack_code] = 1'b1;
    end

    // A set in the same cycle as the clear wins, so a request that
    // lands during its own acknowledge is not lost.
    pending_next = set_vec | (pending & ~clr_vec);

    // An overflow is a new edge on a line that is pending and not being
    // cleared. A fresh overflow beats clr_ovf in the same cycle.
    ovf_next = (edge_mode & rise & pending & ~clr_vec)
             | (ovf & {N_IRQ{~clr_ovf}});

    visible_next = pending_next & ~mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_d       <= '0;
      pending   <= '0;
      pend_out  <= '0;
      irq_valid <= 1'b0;
      ack_err   <= 1'b0;
      ovf       <= '0;
    end else begin
      s_d       <= s;
      pending   <= pending_next;
      pend_out  <= visible_next;
      irq_valid <= |visible_next;
      ack_err   <= ack & ~pend_out[ack_code];
      ovf       <= ovf_next;
    end
  end

endmodule

// File: tb/tb_irq_request_latch.sv
module tb_irq_request_latch;

  logic       clk;
  logic       rst;
  logic [7:0] irq_in;
  logic [7:0] edge_mode;
  logic [7:0] mask;
  logic [7:0] pend_out;
  logic       irq_valid;
  logic       ack;
  logic [2:0] ack_code;
  logic       ack_err;
  logic [7:0] ovf;
  logic       clr_ovf;

  int total = 0;
  int bad   = 0;

  irq_request_latch #(.SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .irq_in    (irq_in),
    .edge_mode (edge_mode),
    .mask      (mask),
    .pend_out  (pend_out),
    .irq_valid (irq_valid),
    .ack       (ack),
    .ack_code  (ack_code),
    .ack_err   (ack_err),
    .ovf       (ovf),
    .clr_ovf   (clr_ovf)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] irq;
    logic [7:0] edge_m;
    logic [7:0] mask;
    logic       ack;
    logic [2:0] code;
    logic       clr_ovf;
    logic [7:0] e_pend;
    logic       e_valid;
    logic       e_err;
    logic [7:0] e_ovf;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input logic r, input logic [7:0] irq, input logic [7:0] em,
                         input logic [7:0] mk, input logic a, input logic [2:0] code,
                         input logic co, input logic [7:0] ep, input logic ev,
                         input logic ee, input logic [7:0] eo);
    vec_t v;
    v.rst = r; v.irq = irq; v.edge_m = em; v.mask = mk; v.ack = a; v.code = code;
    v.clr_ovf = co; v.e_pend = ep; v.e_valid = ev; v.e_err = ee; v.e_ovf = eo;
    vq.push_back(v);
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [7:0] ep, input logic ev,
                           input logic ee, input logic [7:0] eo);
    check8({name, ".pend_out"}, pend_out, ep);
    check8({name, ".irq_valid"}, {7'd0, irq_valid}, {7'd0, ev});
    check8({name, ".ack_err"}, {7'd0, ack_err}, {7'd0, ee});
    check8({name, ".ovf"}, ovf, eo);
  endtask

  task automatic pulse_edge(input logic [7:0] lines);
    irq_in = lines; tick();
    irq_in = 8'h00; tick(); tick();
  endtask

  initial begin
    rst = 1'b1; irq_in = '0; edge_mode = '0; mask = '0;
    ack = 1'b0; ack_code = '0; clr_ovf = 1'b0;

    //       rst irq    edge   mask   ack code clr  pend   v  err ovf
    // reset state
    add_vec(1, 8'h00, 8'h00, 8'h00, 0, 3'd0, 0, 8'h00, 0, 0, 8'h00);
    // edge capture on line 5, visible 3 clocks after the sample
    add_vec(0, 8'h20, 8'hFF, 8'h00, 0, 3'd0, 0, 8'h00, 0, 0, 8'h00);
    add_vec(0, 8'h00, 8'hFF, 8'h00, 0, 3'd0, 0, 8'h00, 0, 0, 8'h00);
    add_vec(0, 8'h00, 8'hFF, 8'h00, 0, 3'd0, 0, 8'h20, 1, 0, 8'h00);
    add_vec(0, 8'h00, 8'hFF, 8'h00, 1, 3'd5, 0, 8'h00, 0, 0, 8'h00);
    add_vec(0, 8'h00, 8'hFF, 8'h00, 0, 3'd0, 0, 8'h00, 0, 0, 8'h00);
    // spurious ack while idle
    add_vec(0, 8'h00, 8'hFF, 8'h00, 1, 3'd0, 0, 8'h00, 0, 1, 8'h00);
    add_vec(0, 8'h00, 8'hFF, 8'h00, 0, 3'd0, 0, 8'h00, 0, 0, 8'h00);
    // level line 2 held high, ack does not open a gap
    add_vec(0, 8'h04, 8'h00, 8'h00, 0, 3'd0, 0, 8'h00, 0, 0, 8'h00);
    add_vec(0, 8'h04, 8'h00, 8'h00, 0, 3'd0, 0, 8'h00, 0, 0, 8'h00);
    add_vec(0, 8'h04, 8'h00, 8'h00, 0, 3'd0, 0, 8'h04, 1, 0, 8'h00);
    add_vec(0, 8'h04, 8'h00, 8'h00, 1, 3'd2, 0, 8'h04, 1, 0, 8'h00);
    add_vec(0, 8'h04, 8'h00, 8'h00, 0, 3'd0, 0, 8'h04, 1, 0, 8'h00);
    add_vec(0, 8'h00, 8'h00, 8'h00, 0, 3'd0, 0, 8'h04, 1, 0, 8'h00);
    add_vec(0, 8'h00, 8'h00, 8'h00, 0, 3'd0, 0, 8'h04, 1, 0, 8'h00);
    add_vec(0, 8'h00, 8'h00, 8'h00, 1, 3'd2, 0, 8'h00, 0, 0, 8'h00);
    add_vec(0, 8'h00, 8'h00, 8'h00, 0, 3'd0, 0, 8'h00, 0, 0, 8'h00);
    // mask: edges on 7 and 0, line 7 masked
    add_vec(0, 8'h81, 8'hFF, 8'h80, 0, 3'd0, 0, 8'h00, 0, 0, 8'h00);
    add_vec(0, 8'h00, 8'hFF, 8'h80, 0, 3'd0, 0, 8'h00, 0, 0, 8'h00);
    add_vec(0, 8'h00, 8'hFF, 8'h80, 0, 3'd0, 0, 8'h01, 1, 0, 8'h00);
    add_vec(0, 8'h00, 8'hFF, 8'h80, 1, 3'd7, 0, 8'h01, 1, 1, 8'h00);
    add_vec(0, 8'h00, 8'hFF, 8'h00, 0, 3'd0, 0, 8'h81, 1, 0, 8'h00);
    add_vec(0, 8'h00, 8'hFF, 8'h00, 1, 3'd7, 0, 8'h01, 1, 0, 8'h00);
    add_vec(0, 8'h00, 8'hFF, 8'h00, 1, 3'd0, 0, 8'h00, 0, 0, 8'h00);

    tick();
    foreach (vq[i]) begin
      rst = vq[i].rst; irq_in = vq[i].irq; edge_mode = vq[i].edge_m; mask = vq[i].mask;
      ack = vq[i].ack; ack_code = vq[i].code; clr_ovf = vq[i].clr_ovf;
      tick();
      check_all($sformatf("vec%0d", i), vq[i].e_pend, vq[i].e_valid, vq[i].e_err, vq[i].e_ovf);
    end
    ack = 1'b0; ack_code = '0; rst = 1'b0; irq_in = '0; edge_mode = 8'hFF; mask = '0;
    tick();

    // set/clear collision on line 3
    pulse_edge(8'h08);
    check_all("coll_first", 8'h08, 1, 0, 8'h00);
    irq_in = 8'h08; tick();
    irq_in = 8'h00; tick();
    ack = 1'b1; ack_code = 3'd3; tick();
    ack = 1'b0;
    check_all("coll_same_cycle", 8'h08, 1, 0, 8'h00);
    pulse_edge(8'h08);
    check_all("coll_ovf", 8'h08, 1, 0, 8'h08);
    tick(); tick();
    check_all("coll_ovf_sticky", 8'h08, 1, 0, 8'h08);
    clr_ovf = 1'b1; tick();
    clr_ovf = 1'b0;
    check_all("coll_clr_ovf", 8'h08, 1, 0, 8'h00);
    ack = 1'b1; ack_code = 3'd3; tick();
    ack = 1'b0;
    check_all("coll_ack", 8'h00, 0, 0, 8'h00);

    // reset mid-operation, line 0 held high through reset
    pulse_edge(8'hFF);
    pulse_edge(8'h0F);
    check_all("pre_reset", 8'hFF, 1, 0, 8'h0F);
    irq_in = 8'h01; tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    check_all("reset_mid", 8'h00, 0, 0, 8'h00);
    tick();
    check_all("post_rst1", 8'h00, 0, 0, 8'h00);
    tick();
    check_all("post_rst2", 8'h00, 0, 0, 8'h00);
    tick();
    check_all("post_rst3", 8'h01, 1, 0, 8'h00);
    irq_in = 8'h00;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
